// File: rtl/uart_rx_8n1.sv
// uart_rx_8n1 -- 16x oversampling 8N1 UART receiver.
//
// Produces the 8-bit control byte for the downstream core from the raw serial
// line. The last correctly framed byte is held on data_out between frames.
//
// Ports:
//   clk        system clock, all logic on the rising edge
//   rst        asynchronous active-high reset
//   uart_in    raw serial line, idle high, asynchronous to clk
//   data_out   last good received byte, held until the next good frame
//   data_valid one-cycle pulse when data_out is updated
//   frame_err  one-cycle pulse when a frame's stop bit samples low
//   busy       high while a frame is in progress (state != IDLE)
module uart_rx_8n1 #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_in,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_err,
    output logic       busy
);
    localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

    state_t        state;
    logic          rx_meta;
    logic          rx_s;
    logic [DW-1:0] divcnt;
    logic          tick;
    logic [3:0]    tcnt;
    logic [2:0]    bitcnt;
    logic [7:0]    shift;

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= uart_in;
            rx_s    <= rx_meta;
        end
    end

    assign tick = (divcnt == DW'(DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            divcnt     <= '0;
            tcnt       <= '0;
            bitcnt     <= '0;
            shift      <= '0;
            data_out   <= 8'h00;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            divcnt     <= tick ? '0 : divcnt + 1'b1;

            case (state)
                IDLE: begin
                    // Restart the tick divider on the falling edge so every
                    // later sample point is measured from the start of the frame.
                    if (!rx_s) begin
                        state  <= START;
                        divcnt <= '0;
                        tcnt   <= '0;
                        busy   <= 1'b1;
                    end
                end
                START: begin
                    if (tick) begin
                        if (tcnt == 4'd7) begin
                            // Mid start bit: a high line here was only a glitch.
                            if (rx_s) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end else begin
                                state  <= DATA;
                                tcnt   <= '0;
                                bitcnt <= '0;
                            end
                        end else begin
                            tcnt <= tcnt + 4'd1;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        // tcnt wraps 15 -> 0, so each bit starts a fresh count.
                        tcnt <= tcnt + 4'd1;
                        if (tcnt == 4'd15) begin
                            shift[bitcnt] <= rx_s;
                            bitcnt        <= bitcnt + 3'd1;
                            if (bitcnt == 3'd7) state <= STOP;
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        tcnt <= tcnt + 4'd1;
                        if (tcnt == 4'd15) begin
                            if (rx_s) begin
                                data_out   <= shift;
                                data_valid <= 1'b1;
                                state      <= IDLE;
                                busy       <= 1'b0;
                            end else begin
                                frame_err <= 1'b1;
                                state     <= BRK;
                            end
                        end
                    end
                end
                BRK: begin
                    // A line held low must go high before a new start is accepted.
                    if (rx_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_8n1.sv
// tb_uart_rx_8n1 -- self-checking bench for uart_rx_8n1.
//
// Frames are generated bit by bit on uart_in; each frame's outcome (good byte
// or framing error) and the clock cycle its flag is due are queued by the
// sender. A per-cycle checker matches every flag against that queue and keeps
// the expected held byte, which data_out must equal on every cycle.
module tb_uart_rx_8n1;
    localparam int DIV = 10;
    localparam int BIT = 16 * DIV;
    localparam int LAT = 3 + 152 * DIV;  // falling edge to visible flag

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       uart_in = 1'b1;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       busy;

    uart_rx_8n1 #(
        .CLK_FREQ  (1_600_000),
        .BAUD      (10_000),
        .OVERSAMPLE(16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .uart_in   (uart_in),
        .data_out  (data_out),
        .data_valid(data_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        bit         good;
        longint     due;
    } exp_t;

    exp_t       q[$];
    exp_t       e;
    logic [7:0] hold = 8'h00;
    longint     cyc = 0;
    longint     vlast = 0;
    longint     vprev = 0;
    int         nvalid = 0;
    int         nerr = 0;
    int         errors = 0;
    int         checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_rng(input string name, input longint act, input longint lo, input longint hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
        end
    endtask

    // Compare process: runs 1 time unit after every rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (rst) begin
                chk("rst_data_out", data_out, 8'h00);
                chk("rst_flags_busy", {data_valid, frame_err, busy}, 3'b000);
            end else begin
                chk("flags_exclusive", data_valid & frame_err, 1'b0);
                if (data_valid || frame_err) begin
                    if (q.size() == 0) begin
                        chk("unexpected_flag", {data_valid, frame_err}, 2'b00);
                    end else begin
                        e = q.pop_front();
                        chk("valid_kind", data_valid, e.good);
                        chk("err_kind", frame_err, !e.good);
                        chk_rng("flag_time", cyc, e.due - 2, e.due + 2);
                        chk("busy_at_flag", busy, !e.good);
                        if (e.good) hold = e.data;
                    end
                    if (data_valid) begin
                        vprev = vlast;
                        vlast = cyc;
                        nvalid++;
                    end
                    if (frame_err) nerr++;
                end else if (q.size() > 0 && cyc > q[0].due + 2) begin
                    chk("flag_timeout", cyc, q[0].due);
                    void'(q.pop_front());
                end
                chk("data_out", data_out, hold);
            end
        end
    end

    // Drives one frame starting at a falling clock edge; stop=0 leaves the line low.
    task automatic send(input logic [7:0] b, input bit stop, input int per);
        q.push_back('{data: b, good: stop, due: cyc + LAT});
        uart_in = 1'b0;
        repeat (per) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_in = b[i];
            repeat (per) @(negedge clk);
        end
        uart_in = stop;
        repeat (per) @(negedge clk);
    endtask

    initial begin
        logic [7:0] rb;
        bit         rs;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("idle_busy", busy, 1'b0);

        // Single frame
        send(8'hA5, 1'b1, BIT);
        repeat (100) @(negedge clk);
        chk("a5_data", data_out, 8'hA5);
        chk("a5_nvalid", nvalid, 1);
        chk("a5_nerr", nerr, 0);
        chk("a5_busy", busy, 1'b0);

        // Back-to-back frames, no idle gap
        send(8'h3C, 1'b1, BIT);
        send(8'hC3, 1'b1, BIT);
        repeat (100) @(negedge clk);
        chk_rng("b2b_spacing", vlast - vprev, 1584, 1616);
        chk("b2b_data", data_out, 8'hC3);
        chk("b2b_nvalid", nvalid, 3);

        // Short low glitch on an idle line
        uart_in = 1'b0;
        repeat (40) @(negedge clk);
        uart_in = 1'b1;
        repeat (200) @(negedge clk);
        chk("glitch_data", data_out, 8'hC3);
        chk("glitch_nvalid", nvalid, 3);
        chk("glitch_nerr", nerr, 0);
        chk("glitch_busy", busy, 1'b0);

        // Framing error, line held low, then recovery
        send(8'h55, 1'b0, BIT);
        repeat (500) @(negedge clk);
        chk("break_busy", busy, 1'b1);
        uart_in = 1'b1;
        repeat (50) @(negedge clk);
        chk("ferr_nerr", nerr, 1);
        chk("ferr_nvalid", nvalid, 3);
        chk("ferr_data", data_out, 8'hC3);
        chk("ferr_busy", busy, 1'b0);
        send(8'h0F, 1'b1, BIT);
        repeat (100) @(negedge clk);
        chk("rec_data", data_out, 8'h0F);
        chk("rec_nvalid", nvalid, 4);

        // Reset in the middle of bit 4 of 8'hFF
        uart_in = 1'b0;
        repeat (BIT) @(negedge clk);
        uart_in = 1'b1;
        repeat (4 * BIT + BIT / 2) @(negedge clk);
        rst = 1'b1;
        q.delete();
        hold = 8'h00;
        #1;
        chk("rst_async_data", data_out, 8'h00);
        chk("rst_async_busy", busy, 1'b0);
        @(negedge clk);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        send(8'h81, 1'b1, BIT);
        repeat (100) @(negedge clk);
        chk("post_rst_data", data_out, 8'h81);

        // Line 3% fast
        send(8'h96, 1'b1, 155);
        repeat (100) @(negedge clk);
        chk("fast_data", data_out, 8'h96);

        // Random frames: random bytes, gaps, rate within tolerance, some bad stops
        for (int n = 0; n < 16; n++) begin
            repeat ($urandom_range(0, 40)) @(negedge clk);
            rb = 8'($urandom);
            rs = ($urandom_range(0, 5) != 0);
            send(rb, rs, $urandom_range(156, 164));
            if (!rs) begin
                repeat ($urandom_range(0, 300)) @(negedge clk);
                uart_in = 1'b1;
                repeat (BIT) @(negedge clk);
            end
        end

        repeat (300) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        chk("final_busy", busy, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
